// File: rtl/ifq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifq_pkg
// Description : Shared types and helpers for the instruction fetch queue.
//               Holds the entry type (pc + instruction) and the clamped
//               pop-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ifq_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } ifq_entry_t;

    // Decode may ask for more than is available; never pop past occupancy.
    function automatic logic [31:0] ifq_pop_count(input logic [31:0] req,
                                                  input logic [31:0] avail);
        return (req < avail) ? req : avail;
    endfunction

endpackage : ifq_pkg
`default_nettype wire

// File: rtl/ifq_align.sv
`default_nettype none
// ============================================================================
// Module      : ifq_align
// Description : Combinational line aligner. Drops the words of a fetched
//               SRAM line that precede the fetch PC and left-compacts the
//               kept words together with their PCs.
// Revision    : 1.0 - initial release
// ============================================================================
module ifq_align
    import ifq_pkg::*;
#(
    parameter int FETCH_WIDTH = 2
) (
    input  logic [PC_W-1:0]               fetch_pc,
    input  logic [INST_W*FETCH_WIDTH-1:0] fetch_rdata,
    output logic [$clog2(FETCH_WIDTH):0]  n_push,
    output ifq_entry_t [FETCH_WIDTH-1:0]  entries
);

    localparam int              c_NP_W      = $clog2(FETCH_WIDTH) + 1;
    localparam logic [PC_W-1:0] c_LINE_MASK = PC_W'(FETCH_WIDTH * 4 - 1);

    logic [31:0]     w_lane;
    logic [PC_W-1:0] w_base;

    // Lane arithmetic is done on full-width values so FETCH_WIDTH=1 needs
    // no zero-width slice.
    assign w_lane = (fetch_pc >> 2) & 32'(FETCH_WIDTH - 1);
    assign w_base = fetch_pc & ~c_LINE_MASK;
    assign n_push = c_NP_W'(32'(FETCH_WIDTH) - w_lane);

    // Shift words lane..FETCH_WIDTH-1 down to slot 0 and rebuild their PCs.
    always_comb begin
        entries = '0;
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            if (int'(w_lane) + j < FETCH_WIDTH) begin
                entries[j].inst = fetch_rdata[INST_W*(int'(w_lane) + j) +: INST_W];
                entries[j].pc   = w_base + PC_W'(4 * (int'(w_lane) + j));
            end
        end
    end

endmodule : ifq_align
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_queue
// Description : Circular instruction queue between the inst SRAM and the
//               multi-issue decode stage. Accepts aligned/unaligned fetch
//               lines, presents up to ISSUE_WIDTH oldest instructions, and
//               supports flush.
//               Optional macro IFQ_BYPASS_EN: when the queue is empty, a
//               pushed line is visible (and poppable) in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_queue
    import ifq_pkg::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             fetch_valid,
    input  logic [PC_W-1:0]                  fetch_pc,
    input  logic [INST_W*FETCH_WIDTH-1:0]    fetch_rdata,
    output logic                             fetch_ready,
    input  logic [$clog2(ISSUE_WIDTH):0]     issue_count,
    output logic [ISSUE_WIDTH-1:0]           out_valid,
    output logic [INST_W*ISSUE_WIDTH-1:0]    out_inst,
    output logic [PC_W*ISSUE_WIDTH-1:0]      out_pc,
    output logic [$clog2(DEPTH):0]           count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam int c_NP_W  = $clog2(FETCH_WIDTH) + 1;

    logic [c_NP_W-1:0]               w_n_push;
    ifq_entry_t [FETCH_WIDTH-1:0]    w_entries;
    logic                            w_push;
    logic [c_CNT_W-1:0]              w_avail;
    logic [c_CNT_W-1:0]              w_n_pop;
    logic [c_CNT_W-1:0]              w_push_cnt;

    ifq_entry_t                      r_mem [DEPTH];
    logic [c_PTR_W-1:0]              r_head;
    logic [c_PTR_W-1:0]              r_tail;
    logic [c_CNT_W-1:0]              r_count;

    ifq_align #(
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_align (
        .fetch_pc    (fetch_pc),
        .fetch_rdata (fetch_rdata),
        .n_push      (w_n_push),
        .entries     (w_entries)
    );

    // Readiness uses the registered count only, keeping issue_count off
    // the fetch_ready path.
    assign fetch_ready = (r_count <= c_CNT_W'(DEPTH - FETCH_WIDTH));
    assign w_push      = fetch_valid & fetch_ready & ~flush;
    assign w_push_cnt  = w_push ? c_CNT_W'(w_n_push) : '0;
    assign count       = r_count;

`ifdef IFQ_BYPASS_EN
    logic w_bypass;
    assign w_bypass = w_push && (r_count == '0);
    assign w_avail  = w_bypass ? c_CNT_W'(w_n_push) : r_count;
`else
    assign w_avail  = r_count;
`endif

    assign w_n_pop = c_CNT_W'(ifq_pop_count(32'(issue_count), 32'(w_avail)));

    // Pointer and occupancy bookkeeping; flush collapses head onto tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PTR_W'(w_n_push);
            end
            r_head  <= r_head + c_PTR_W'(w_n_pop);
            r_count <= r_count + w_push_cnt - w_n_pop;
        end
    end

    // Entry storage: kept words land at tail, tail+1, ... in program order.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (k < int'(w_n_push)) begin
                    r_mem[r_tail + c_PTR_W'(k)] <= w_entries[k];
                end
            end
        end
    end

    // Issue window: slot i shows the i-th oldest entry, zero when empty.
    always_comb begin
        out_valid = '0;
        out_inst  = '0;
        out_pc    = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
`ifdef IFQ_BYPASS_EN
            if (w_bypass) begin
                if (i < FETCH_WIDTH && i < int'(w_n_push)) begin
                    out_valid[i]                = 1'b1;
                    out_inst[INST_W*i +: INST_W] = w_entries[i].inst;
                    out_pc[PC_W*i +: PC_W]       = w_entries[i].pc;
                end
            end else
`endif
            if (int'(r_count) > i) begin
                out_valid[i]                 = 1'b1;
                out_inst[INST_W*i +: INST_W] = r_mem[r_head + c_PTR_W'(i)].inst;
                out_pc[PC_W*i +: PC_W]       = r_mem[r_head + c_PTR_W'(i)].pc;
            end
        end
    end

endmodule : inst_fetch_queue
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_queue
// Description : Self-checking bench for inst_fetch_queue (FETCH_WIDTH=2,
//               ISSUE_WIDTH=2, DEPTH=8) using a queue-based scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;

    localparam int FW = 2;
    localparam int IW = 2;
    localparam int D  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic [63:0] fetch_rdata = '0;
    logic [1:0]  issue_count = '0;
    logic        fetch_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_inst;
    logic [63:0] out_pc;
    logic [3:0]  count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    inst_fetch_queue #(
        .FETCH_WIDTH (FW),
        .ISSUE_WIDTH (IW),
        .DEPTH       (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_rdata (fetch_rdata),
        .fetch_ready (fetch_ready),
        .issue_count (issue_count),
        .out_valid   (out_valid),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .count       (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return pc ^ 32'h2400_5A5A;
    endfunction

    function automatic logic [63:0] mk_line(input logic [31:0] pc);
        logic [31:0] base;
        base = pc & ~32'h7;
        return {mk_inst(base + 32'd4), mk_inst(base)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int          sz;
        logic        v;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        sz = q.size();
        chk({tag, ":count"}, 32'(count), 32'(sz));
        chk({tag, ":fetch_ready"}, 32'(fetch_ready), (D - sz >= FW) ? 32'd1 : 32'd0);
        for (int i = 0; i < IW; i++) begin
            v      = (i < sz);
            e_inst = v ? q[i].inst : 32'd0;
            e_pc   = v ? q[i].pc   : 32'd0;
            chk($sformatf("%s:valid%0d", tag, i), 32'(out_valid[i]), 32'(v));
            chk($sformatf("%s:inst%0d", tag, i), out_inst[32*i +: 32], e_inst);
            chk($sformatf("%s:pc%0d", tag, i), out_pc[32*i +: 32], e_pc);
        end
    endtask

    // One clock: drive at negedge, update scoreboard at posedge, check at +1.
    task automatic step(input string tag, input bit r, input bit fv,
                        input logic [31:0] pc, input logic [63:0] data,
                        input int ic, input bit fl);
        bit ready;
        int npop;
        @(negedge clk);
        rst         = r;
        fetch_valid = fv;
        fetch_pc    = pc;
        fetch_rdata = data;
        issue_count = 2'(ic);
        flush       = fl;
        ready       = (D - q.size() >= FW);
        @(posedge clk);
        if (r || fl) begin
            q.delete();
        end else begin
            npop = (ic < q.size()) ? ic : q.size();
            repeat (npop) void'(q.pop_front());
            if (fv && ready) begin
                for (int k = int'(pc[2]); k < FW; k++) begin
                    q.push_back('{pc: (pc & ~32'h7) + 32'(4 * k), inst: data[32*k +: 32]});
                end
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic push(input string tag, input logic [31:0] pc, input int ic);
        step(tag, 1'b0, 1'b1, pc, mk_line(pc), ic, 1'b0);
    endtask

    task automatic idle(input string tag, input int ic);
        step(tag, 1'b0, 1'b0, 32'd0, 64'd0, ic, 1'b0);
    endtask

    initial begin
        logic [31:0] pc;

        // Reset dominates concurrent fetch/flush/issue activity.
        step("rst0", 1'b1, 1'b1, 32'hBFC0_0000, 64'h1111_2222_3333_4444, 2, 1'b1);
        step("rst1", 1'b1, 1'b0, 32'd0, 64'd0, 0, 1'b0);
        idle("idle", 0);
        chk("reset:out_inst", out_inst[31:0] | out_inst[63:32], 32'd0);

        // Aligned line.
        step("aligned", 1'b0, 1'b1, 32'hBFC0_0000, 64'h2402_0002_2401_0001, 0, 1'b0);
        chk("aligned:slot0_inst", out_inst[31:0], 32'h2401_0001);
        chk("aligned:slot1_pc", out_pc[63:32], 32'hBFC0_0004);

        // Drain, then unaligned line keeps only the upper word.
        idle("drain", 2);
        step("unaligned", 1'b0, 1'b1, 32'hBFC0_0004, 64'h2402_0002_2401_0001, 0, 1'b0);
        chk("unaligned:slot0_inst", out_inst[31:0], 32'h2402_0002);
        chk("unaligned:valid", 32'(out_valid), 32'h1);
        idle("unaligned_pop", 2);

        // Fill to full, drop an extra fetch, then drain with clamping.
        push("fill0", 32'h0000_1000, 0);
        push("fill1", 32'h0000_1008, 0);
        push("fill2", 32'h0000_1010, 0);
        push("fill3", 32'h0000_1018, 0);
        chk("full:count", 32'(count), 32'd8);
        chk("full:fetch_ready", 32'(fetch_ready), 32'd0);
        push("dropped", 32'h0000_1020, 0);
        idle("pop_to6", 2);
        chk("pop_to6:fetch_ready", 32'(fetch_ready), 32'd1);
        idle("pop_to4", 2);
        idle("pop_to2", 2);
        idle("pop_to1", 1);
        idle("clamp", 2);
        chk("clamp:count", 32'(count), 32'd0);

        // Steady push+pop across several pointer wraps.
        pc = 32'h0000_2000;
        for (int c = 0; c < 20; c++) begin
            push($sformatf("wrap%0d", c), pc, 2);
            pc += 32'd8;
        end

        // Build count=5 then flush with a colliding push and pop.
        push("pre5a", 32'h0000_3000, 0);
        push("pre5b", 32'h0000_300C, 0);
        chk("pre5:count", 32'(count), 32'd5);
        step("flush", 1'b0, 1'b1, 32'h0000_4000, mk_line(32'h0000_4000), 2, 1'b1);
        chk("flush:out_valid", 32'(out_valid), 32'd0);
        push("post_flush", 32'h0000_5000, 0);
        chk("post_flush:slot0_pc", out_pc[31:0], 32'h0000_5000);

        // Mixed random traffic.
        pc = 32'h0001_0000;
        for (int c = 0; c < 60; c++) begin
            logic [31:0] rpc;
            rpc = pc | (($urandom_range(0, 1) != 0) ? 32'h4 : 32'h0);
            step($sformatf("rand%0d", c), 1'b0, ($urandom_range(0, 3) != 0),
                 rpc, mk_line(rpc), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 15) == 0));
            pc += 32'd8;
        end
        idle("final", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_inst_fetch_queue
`default_nettype wire
